// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute-stage control and the multiply/divide unit.
// The control side drives operands and requests; the unit returns busy/done and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in FIX before the HI/LO write.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic             is_div, neg_a, neg_b, b_zero;
    logic [WIDTH-1:0] opb, acc_hi, acc_lo;

    logic             accept;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_hi, res_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign2(input logic signed [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (2*WIDTH)'(-v) : (2*WIDTH)'(v);
    endfunction

    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ok   = (div_sh >= {1'b0, opb});
        div_diff = div_sh - {1'b0, opb};
        if (is_div) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction; a zero divisor keeps the all-ones quotient unnegated
    always_comb begin
        if (is_div) begin
            res_lo = magnitude(acc_lo, (neg_a ^ neg_b) && !b_zero);
            res_hi = magnitude(acc_hi, neg_a);
        end else begin
            {res_hi, res_lo} = apply_sign2({acc_hi, acc_lo}, neg_a ^ neg_b);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == '1) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == FIX);
            if (accept)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + CNT_W'(1);
            if (state == FIX) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_we) hi_r <= bus.rs_data;
                if (bus.lo_we) lo_r <= bus.rs_data;
            end
        end
    end

    // Operand/accumulator datapath; only meaningful while RUN/FIX
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= bus.op[1];
            neg_a  <= !bus.op[0] && bus.rs_data[WIDTH-1];
            neg_b  <= !bus.op[0] && bus.rt_data[WIDTH-1];
            b_zero <= (bus.rt_data == '0);
            acc_hi <= '0;
            acc_lo <= magnitude(bus.rs_data, !bus.op[0] && bus.rs_data[WIDTH-1]);
            opb    <= magnitude(bus.rt_data, !bus.op[0] && bus.rt_data[WIDTH-1]);
        end else if (state == RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute datapath. It consumes register-file operands rs/rt, and its HI/LO values feed the write-back mux for MFHI/MFLO.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Supports MTHI/MTLO direct writes.
- The control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  multiplicand or dividend; also the MTHI/MTLO source.
- rt_data  input  WIDTH  multiplier or divisor.
- hi_we  input  1  MTHI: write rs_data into HI.
- lo_we  input  1  MTLO: write rs_data into LO.
- busy  output  1  operation in progress; the PC must not advance.
- done  output  1  one-cycle pulse; HI/LO hold a new result.
- hi  output  WIDTH  HI register (product upper half, or remainder).
- lo  output  WIDTH  LO register (product lower half, or quotient).

Behaviour:
- Reset (asynchronous, immediate): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-operation aborts it; no partial result reaches HI/LO.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 at an edge latches op, rs_data and rt_data. For signed ops it also latches operand magnitudes and result-sign flags.
  - The FSM moves to RUN with counter=0; busy=1 from that edge.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. Counter increments each edge; after the edge where counter=31 the FSM moves to FIX.
- FIX:
  - Applies two's-complement sign correction.
  - Next edge writes HI/LO, FSM=IDLE, busy=0, done=1 for exactly that one cycle.
  - A start at a done-cycle edge is accepted normally.
- Latency: start accepted at edge E0 -> HI/LO updated and done high after edge E33. busy is high 33 cycles.
- Multiply: {hi,lo} = full 64-bit product.
  - MULTU treats operands as unsigned.
  - MULT treats operands as two's complement; product negated if the operand signs differ.
- Divide: lo = quotient truncated toward zero; hi = remainder, whose sign matches the dividend (MIPS semantics).
  - Divide by zero (rt_data=0, DIV or DIVU): lo=32'hFFFF_FFFF, hi=rs_data as latched. Full 33-cycle latency; no exception.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. This falls out of the magnitude algorithm; no special case needed.
- start while busy=1 is ignored; the operation in progress is unaffected.
- hi_we/lo_we:
  - Take effect at the edge only when busy=0 and no start is accepted in that cycle.
  - If start and hi_we/lo_we are asserted together, start wins and the writes are dropped.
  - hi_we and lo_we together write both registers.
  - Both are ignored while busy=1.
- hi/lo hold their values throughout RUN/FIX. The old result stays readable until the write edge.
- op, rs_data and rt_data may change freely after acceptance; the latched copies are used.

Test Plan:
- Reset and MULTU: assert reset mid-cycle -> hi=lo=0, busy=0 immediately. Then MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> after 33 busy cycles, hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses one cycle.
- Signed MULT: MULT rs=-3 (32'hFFFF_FFFD), rt=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then MULT 32'h8000_0000 x 32'h8000_0000 -> hi=32'h4000_0000, lo=0.
- Signed DIV: DIV rs=-7, rt=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU rs=100, rt=7 -> lo=14, hi=2.
- Divide edge cases: DIVU rs=32'h1234_5678, rt=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678 after the full latency. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- Start and MTHI/MTLO while busy: start MULTU 5x6; at cycle 10 pulse start with other operands and hi_we=1 -> both ignored, result hi=0, lo=30. While idle, MTLO rs=32'hCAFE_F00D -> lo updates next edge, hi unchanged, done stays 0.
- Reset mid-operation: start DIVU 1000/3 and assert reset at cycle 15 -> busy=0, hi=lo=0, done never pulses. A new start after reset release gives lo=333, hi=1.
